// File: rtl/hwpe_ctrl_job_dispatcher.sv
// HWPE control front-end: decodes peripheral-bus accesses into register-file accesses and
// flags, arbitrates the offload lock and sequences queued jobs into the engine.
// Optional lock auto-release is built when HWPE_CTRL_LOCK_TIMEOUT_EN is defined.
module hwpe_ctrl_job_dispatcher #(
  parameter int N_CONTEXT      = 2,
  parameter int N_GENERIC_REGS = 0,
  parameter int N_IO_REGS      = 2,
  parameter int ID_WIDTH       = 16,
  parameter int LOCK_TIMEOUT   = 1024,
  localparam int CTX_W         = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [31:0]         add_i,
  input  logic                wen_i,
  input  logic [3:0]          be_i,
  input  logic [31:0]         data_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                r_valid_o,
  output logic [31:0]         r_data_o,
  output logic [ID_WIDTH-1:0] r_id_o,
  output logic [6:0]          rf_addr_o,
  output logic                rf_wren_o,
  output logic [31:0]         rf_wdata_o,
  output logic [3:0]          rf_be_o,
  input  logic [31:0]         rf_rdata_i,
  output logic                is_mandatory_o,
  output logic                is_contexted_o,
  output logic                is_read_o,
  output logic                is_testset_o,
  output logic                is_trigger_o,
  output logic                is_critical_o,
  output logic                full_context_o,
  output logic                true_done_o,
  output logic [CTX_W-1:0]    pointer_context_o,
  output logic [CTX_W-1:0]    running_context_o,
  output logic                start_o,
  input  logic                done_i,
  output logic                evt_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(N_CONTEXT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_CONTEXT);

  localparam logic LOCK_FREE = 1'b0;
  localparam logic LOCK_HELD = 1'b1;

  localparam logic [1:0] ENG_IDLE  = 2'd0;
  localparam logic [1:0] ENG_START = 2'd1;
  localparam logic [1:0] ENG_RUN   = 2'd2;

  localparam logic [4:0] IDX_TRIGGER   = 5'd0;
  localparam logic [4:0] IDX_ACQUIRE   = 5'd1;
  localparam logic [4:0] IDX_SOFTCLEAR = 5'd5;
  localparam logic [4:0] IDX_FIRST_GEN = 5'd8;
  localparam logic [4:0] IDX_FIRST_CTX = 5'(8 + N_GENERIC_REGS);

  logic                lock_q, lock_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CTX_W-1:0]    ptr_q, ptr_d;
  logic [CTX_W-1:0]    run_q, run_d;
  logic [1:0]          eng_q, eng_d;
  logic                evt_q, evt_d;
  logic                r_valid_q, r_valid_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;

  logic [4:0] idx;
  logic [1:0] ctx_sel;
  logic       is_write;
  logic       owner_hit;
  logic       acquire_ok;
  logic       soft_clear;
  logic       do_clear;
  logic       lock_expired;
  logic       unused_add;

  assign unused_add = ^{add_i[31:9], add_i[1:0]};

  // Context count is a power of two, so a plain increment wraps modulo N_CONTEXT.
  function automatic logic [CTX_W-1:0] ctx_inc(input logic [CTX_W-1:0] p);
    return (N_CONTEXT == 1) ? '0 : CTX_W'(p + 1'b1);
  endfunction

  always_comb begin
    idx            = add_i[6:2];
    is_write       = req_i & ~wen_i;
    is_mandatory_o = req_i & (idx < IDX_FIRST_GEN);
    is_contexted_o = req_i & (idx >= IDX_FIRST_CTX);
    is_read_o      = req_i & wen_i;
    is_testset_o   = is_read_o & (idx == IDX_ACQUIRE);
    owner_hit      = (lock_q == LOCK_HELD) & (id_i == owner_q);
    is_trigger_o   = is_write & (idx == IDX_TRIGGER) & owner_hit;
    is_critical_o  = is_testset_o & (lock_q == LOCK_HELD);
    full_context_o = is_testset_o & (lock_q == LOCK_FREE) & (count_q == CNT_FULL);
    acquire_ok     = is_testset_o & (lock_q == LOCK_FREE) & (count_q != CNT_FULL);
    soft_clear     = is_write & (idx == IDX_SOFTCLEAR);
    true_done_o    = (eng_q == ENG_RUN) & done_i;
  end

  // Writes land in the context being prepared; reads may inspect any context.
  always_comb begin
    ctx_sel = 2'b00;
    if (is_contexted_o) begin
      if (wen_i) ctx_sel = add_i[8:7];
      else       ctx_sel[CTX_W-1:0] = ptr_q;
    end
    rf_addr_o  = {ctx_sel, idx};
    rf_wren_o  = is_write & (~is_contexted_o | owner_hit);
    rf_wdata_o = req_i ? data_i : '0;
    rf_be_o    = req_i ? be_i : '0;
  end

`ifdef HWPE_CTRL_LOCK_TIMEOUT_EN
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d        = '0;
    lock_expired = 1'b0;
    if ((lock_q == LOCK_HELD) && !(req_i && (id_i == owner_q))) begin
      if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) lock_expired = 1'b1;
      else                                   tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  assign lock_expired = 1'b0;
`endif

  always_comb begin
    lock_d    = lock_q;
    owner_d   = owner_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    run_d     = run_q;
    eng_d     = eng_q;
    evt_d     = true_done_o;
    r_valid_d = req_i;
    r_id_d    = req_i ? id_i : r_id_q;
    do_clear  = clear_i | soft_clear;
    if (do_clear) begin
      lock_d  = LOCK_FREE;
      count_d = '0;
      ptr_d   = '0;
      run_d   = '0;
      eng_d   = ENG_IDLE;
    end else begin
      if (acquire_ok) begin
        lock_d  = LOCK_HELD;
        owner_d = id_i;
      end else if (is_trigger_o || lock_expired) begin
        lock_d = LOCK_FREE;
      end
      if (is_trigger_o) ptr_d = ctx_inc(ptr_q);
      if (true_done_o)  run_d = ctx_inc(run_q);
      // A trigger and a completion in the same cycle cancel in the occupancy count.
      case ({is_trigger_o, true_done_o})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      case (eng_q)
        ENG_IDLE:  if (count_q != '0) eng_d = ENG_START;
        ENG_START: eng_d = ENG_RUN;
        ENG_RUN:   if (done_i) eng_d = ENG_IDLE;
        default:   eng_d = ENG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= LOCK_FREE;
      owner_q   <= '0;
      count_q   <= '0;
      ptr_q     <= '0;
      run_q     <= '0;
      eng_q     <= ENG_IDLE;
      evt_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
    end else begin
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      count_q   <= count_d;
      ptr_q     <= ptr_d;
      run_q     <= run_d;
      eng_q     <= eng_d;
      evt_q     <= evt_d;
      r_valid_q <= r_valid_d;
      r_id_q    <= r_id_d;
    end
  end

  assign gnt_o             = req_i;
  assign r_valid_o         = r_valid_q;
  assign r_id_o            = r_id_q;
  assign r_data_o          = rf_rdata_i;
  assign pointer_context_o = ptr_q;
  assign running_context_o = run_q;
  assign start_o           = (eng_q == ENG_START);
  assign evt_o             = evt_q;
  assign busy_o            = (count_q != '0);

endmodule

// File: tb/tb_hwpe_ctrl_job_dispatcher.sv
// Randomized and directed bench for hwpe_ctrl_job_dispatcher against a job-level reference model.
module tb_hwpe_ctrl_job_dispatcher;
  localparam int NC  = 2;
  localparam int NG  = 0;
  localparam int IDW = 16;
  localparam int LT  = 16;
  localparam int CW  = 1;
  localparam int VW  = 105 + 2 * CW;

  logic clk = 1'b0, rst_n = 1'b1, clear = 1'b0, req = 1'b0, wen = 1'b0, done = 1'b0;
  logic [31:0] add = '0, data = '0, rdata = '0;
  logic [3:0] be = '0;
  logic [IDW-1:0] id = '0;

  logic gnt, r_valid, rf_wren, is_mand, is_ctx, is_read, is_ts, is_trig, is_crit, full_ctx;
  logic true_done, start, evt, busy;
  logic [31:0] r_data, rf_wdata;
  logic [IDW-1:0] r_id;
  logic [6:0] rf_addr;
  logic [3:0] rf_be;
  logic [CW-1:0] ptr_ctx, run_ctx;

  int checks = 0;
  int errors = 0;

  // Reference model: lock, occupancy, context pointers and engine phase
  // (0 waiting for work, 1 issuing start, 2 job in flight).
  bit m_locked, m_evt, m_rvalid;
  int m_owner, m_count, m_ptr, m_run, m_eng, m_tmo;
  logic [IDW-1:0] m_rid;

  hwpe_ctrl_job_dispatcher #(
    .N_CONTEXT(NC), .N_GENERIC_REGS(NG), .N_IO_REGS(2), .ID_WIDTH(IDW), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_i(req), .gnt_o(gnt), .add_i(add),
    .wen_i(wen), .be_i(be), .data_i(data), .id_i(id), .r_valid_o(r_valid), .r_data_o(r_data),
    .r_id_o(r_id), .rf_addr_o(rf_addr), .rf_wren_o(rf_wren), .rf_wdata_o(rf_wdata),
    .rf_be_o(rf_be), .rf_rdata_i(rdata), .is_mandatory_o(is_mand), .is_contexted_o(is_ctx),
    .is_read_o(is_read), .is_testset_o(is_ts), .is_trigger_o(is_trig), .is_critical_o(is_crit),
    .full_context_o(full_ctx), .true_done_o(true_done), .pointer_context_o(ptr_ctx),
    .running_context_o(run_ctx), .start_o(start), .done_i(done), .evt_o(evt), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_locked = 0; m_evt = 0; m_rvalid = 0; m_owner = 0; m_count = 0;
    m_ptr = 0; m_run = 0; m_eng = 0; m_tmo = 0; m_rid = '0;
  endfunction

  function automatic logic [VW-1:0] dut_obs();
    return {gnt, r_valid, r_id, r_data, rf_addr, rf_wren, rf_wdata, rf_be, is_mand, is_ctx,
            is_read, is_ts, is_trig, is_crit, full_ctx, true_done, ptr_ctx, run_ctx, start, evt, busy};
  endfunction

  function automatic logic [VW-1:0] model_exp();
    int idx = int'(add[6:2]);
    bit rd = req && wen;
    bit wr = req && !wen;
    bit ctxd = req && (idx >= 8 + NG);
    bit owner_ok = m_locked && (int'(id) == m_owner);
    bit ts = rd && (idx == 1);
    int ctx = !ctxd ? 0 : (wen ? int'(add[8:7]) : m_ptr);
    logic [6:0] a = 7'(ctx * 32 + idx);
    return {req, m_rvalid, m_rid, rdata, a, wr && (!ctxd || owner_ok), req ? data : 32'h0,
            req ? be : 4'h0, req && (idx < 8), ctxd, rd, ts, wr && (idx == 0) && owner_ok,
            ts && m_locked, ts && !m_locked && (m_count == NC), (m_eng == 2) && done,
            CW'(m_ptr), CW'(m_run), m_eng == 1, m_evt, m_count > 0};
  endfunction

  function automatic void model_step();
    int idx = int'(add[6:2]);
    bit wr = req && !wen;
    bit owner_ok = m_locked && (int'(id) == m_owner);
    bit trig = wr && (idx == 0) && owner_ok;
    bit acq = req && wen && (idx == 1) && !m_locked && (m_count < NC);
    bit fin = (m_eng == 2) && done;
    bit expire = 0;
    int eng_n;
`ifdef HWPE_CTRL_LOCK_TIMEOUT_EN
    if (m_locked && !(req && (int'(id) == m_owner))) begin
      if (m_tmo == LT - 1) begin expire = 1; m_tmo = 0; end
      else m_tmo++;
    end else m_tmo = 0;
`endif
    m_evt = fin;
    m_rvalid = req;
    if (req) m_rid = id;
    if (clear || (wr && idx == 5)) begin
      m_locked = 0; m_count = 0; m_ptr = 0; m_run = 0; m_eng = 0;
      return;
    end
    eng_n = (m_eng == 0) ? ((m_count > 0) ? 1 : 0) : (m_eng == 1) ? 2 : (done ? 0 : 2);
    if (acq) begin m_locked = 1; m_owner = int'(id); end
    else if (trig || expire) m_locked = 0;
    if (trig) m_ptr = (m_ptr + 1) % NC;
    if (fin) m_run = (m_run + 1) % NC;
    m_count = m_count + int'(trig) - int'(fin);
    m_eng = eng_n;
  endfunction

  task automatic drive(input logic r, input logic w, input int idx, input int ctx, input int rid,
                       input logic [31:0] d, input logic dn);
    req = r; wen = w; add = {23'h0, 2'(ctx), 5'(idx), 2'b00}; id = IDW'(rid);
    data = d; be = 4'($urandom); rdata = $urandom; done = dn;
    #1;
  endtask

  task automatic idle(); drive(1'b0, 1'b0, 0, 0, 0, 32'h0, 1'b0); endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; idle(); step(); clear = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rdata = '0;
    rst_n = 1'b0; #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_obs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", dut_obs());
    end
    rst_n = 1'b1;
    idle();
    checks++;
    if (dut_obs() !== model_exp()) begin
      errors++; $display("FAIL reset_idle: got %h want %h", dut_obs(), model_exp());
    end
    step();
  endtask

  task automatic test_single_job();
    do_clear();
    drive(1, 1, 1, 0, 3, 32'h0, 0);
    checks++;
    if ({is_ts, is_crit, full_ctx, is_read, is_mand} !== 5'b10011) begin
      errors++; $display("FAIL sj_acquire_flags: got %b want 10011", {is_ts, is_crit, full_ctx, is_read, is_mand});
    end
    step();
    drive(1, 0, 8, 0, 3, 32'h1234, 0);
    rdata = 32'h0; #1;
    checks++;
    if ({r_valid, r_id, r_data} !== {1'b1, 16'd3, 32'd0}) begin
      errors++; $display("FAIL sj_acquire_resp: got %b/%0d/%h want 1/3/0", r_valid, r_id, r_data);
    end
    checks++;
    if ({rf_wren, rf_addr, rf_wdata, is_ctx} !== {1'b1, 7'h08, 32'h1234, 1'b1}) begin
      errors++; $display("FAIL sj_ctx_write: got wren %b addr %h data %h", rf_wren, rf_addr, rf_wdata);
    end
    step();
    drive(1, 0, 0, 0, 3, 32'h0, 0);
    checks++;
    if (is_trig !== 1'b1) begin errors++; $display("FAIL sj_trigger: got %b want 1", is_trig); end
    step();
    idle();
    checks++;
    if ({start, busy, ptr_ctx} !== {1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sj_queued: got start %b busy %b ptr %0d want 0 1 1", start, busy, ptr_ctx);
    end
    step();
    idle();
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL sj_start_latency: got %b want 1", start); end
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    checks++;
    if ({true_done, start} !== 2'b10) begin
      errors++; $display("FAIL sj_done: got true_done %b start %b want 1 0", true_done, start);
    end
    step();
    idle();
    checks++;
    if ({evt, busy, run_ctx, true_done} !== {1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sj_evt: got evt %b busy %b run %0d want 1 0 1", evt, busy, run_ctx);
    end
    step();
  endtask

  task automatic test_contention();
    do_clear();
    drive(1, 1, 1, 0, 3, 32'h0, 0); step();
    drive(1, 1, 1, 0, 5, 32'h0, 0);
    checks++;
    if ({is_crit, full_ctx} !== 2'b10) begin
      errors++; $display("FAIL ct_critical: got crit %b full %b want 1 0", is_crit, full_ctx);
    end
    step();
    drive(1, 0, 9, 1, 5, 32'hdead_beef, 0);
    checks++;
    if ({rf_wren, is_ctx} !== 2'b01) begin
      errors++; $display("FAIL ct_drop_write: got wren %b ctx %b want 0 1", rf_wren, is_ctx);
    end
    step();
    drive(1, 0, 0, 0, 5, 32'h0, 0);
    checks++;
    if ({r_valid, r_id, is_trig} !== {1'b1, 16'd5, 1'b0}) begin
      errors++; $display("FAIL ct_nonowner: got rvalid %b rid %0d trig %b want 1 5 0", r_valid, r_id, is_trig);
    end
    step();
    drive(1, 0, 0, 0, 3, 32'h0, 0);
    checks++;
    if (is_trig !== 1'b1) begin errors++; $display("FAIL ct_owner_kept: got %b want 1", is_trig); end
    step();
  endtask

  task automatic test_full_queue();
    do_clear();
    for (int j = 0; j < 2; j++) begin
      drive(1, 1, 1, 0, 3 + j, 32'h0, 0); step();
      drive(1, 0, 0, 0, 3 + j, 32'h0, 0); step();
    end
    drive(1, 1, 1, 0, 5, 32'h0, 0);
    checks++;
    if ({full_ctx, is_crit, busy} !== 3'b101) begin
      errors++; $display("FAIL fq_full: got full %b crit %b busy %b want 1 0 1", full_ctx, is_crit, busy);
    end
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    checks++;
    if (true_done !== 1'b1) begin errors++; $display("FAIL fq_done: got %b want 1", true_done); end
    step();
    drive(1, 1, 1, 0, 6, 32'h0, 0);
    checks++;
    if ({is_ts, full_ctx, is_crit} !== 3'b100) begin
      errors++; $display("FAIL fq_reacquire: got ts %b full %b crit %b want 1 0 0", is_ts, full_ctx, is_crit);
    end
    step();
    drive(1, 0, 0, 0, 6, 32'h0, 0);
    checks++;
    if ({ptr_ctx, is_trig} !== {1'b0, 1'b1}) begin
      errors++; $display("FAIL fq_wrap: got ptr %0d trig %b want 0 1", ptr_ctx, is_trig);
    end
    step();
  endtask

  task automatic test_simultaneous();
    do_clear();
    drive(1, 1, 1, 0, 3, 32'h0, 0); step();
    drive(1, 0, 0, 0, 3, 32'h0, 0); step();
    idle(); step();
    idle();
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL si_start: got %b want 1", start); end
    step();
    drive(1, 1, 1, 0, 3, 32'h0, 0); step();
    drive(1, 0, 0, 0, 3, 32'h0, 1);
    checks++;
    if ({is_trig, true_done} !== 2'b11) begin
      errors++; $display("FAIL si_both: got trig %b done %b want 1 1", is_trig, true_done);
    end
    step();
    idle();
    checks++;
    if ({ptr_ctx, run_ctx, busy} !== {1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL si_pointers: got ptr %0d run %0d busy %b want 0 1 1", ptr_ctx, run_ctx, busy);
    end
    step();
    idle();
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL si_restart: got %b want 1", start); end
    step();
  endtask

  task automatic test_softclear();
    do_clear();
    drive(1, 1, 1, 0, 3, 32'h0, 0); step();
    drive(1, 0, 0, 0, 3, 32'h0, 0); step();
    repeat (3) begin idle(); step(); end
    drive(1, 1, 1, 0, 3, 32'h0, 0); step();
    drive(1, 0, 5, 0, 3, 32'h1, 0); step();
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    checks++;
    if ({busy, ptr_ctx, run_ctx, true_done} !== 4'b0000) begin
      errors++; $display("FAIL sc_cleared: got busy %b ptr %0d run %0d done %b want 0", busy, ptr_ctx, run_ctx, true_done);
    end
    step();
    drive(1, 1, 1, 0, 7, 32'h0, 0);
    checks++;
    if ({evt, is_crit, full_ctx, is_ts} !== 4'b0001) begin
      errors++; $display("FAIL sc_lock_free: got evt %b crit %b full %b want 0 0 0", evt, is_crit, full_ctx);
    end
    step();
  endtask

  task automatic test_reset_mid_job();
    do_clear();
    drive(1, 1, 1, 0, 3, 32'h0, 0); step();
    drive(1, 0, 0, 0, 3, 32'h0, 0); step();
    repeat (3) begin idle(); step(); end
    rst_n = 1'b0; #1;
    model_reset();
    checks++;
    if ({busy, start, ptr_ctx, r_valid} !== 4'b0000) begin
      errors++; $display("FAIL rm_reset: got busy %b start %b ptr %0d rvalid %b want 0", busy, start, ptr_ctx, r_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    checks++;
    if (dut_obs() !== model_exp() || true_done !== 1'b0) begin
      errors++; $display("FAIL rm_late_done: got %h want %h", dut_obs(), model_exp());
    end
    step();
  endtask

  task automatic test_lock_hold();
    do_clear();
    drive(1, 1, 1, 0, 3, 32'h0, 0); step();
    repeat (LT) begin idle(); step(); end
    drive(1, 1, 1, 0, 5, 32'h0, 0);
`ifdef HWPE_CTRL_LOCK_TIMEOUT_EN
    checks++;
    if ({is_crit, full_ctx, busy} !== 3'b000) begin
      errors++; $display("FAIL lh_timeout_free: got crit %b full %b busy %b want 0 0 0", is_crit, full_ctx, busy);
    end
    step();
    drive(1, 0, 0, 0, 5, 32'h0, 0);
    checks++;
    if (is_trig !== 1'b1) begin errors++; $display("FAIL lh_new_owner: got %b want 1", is_trig); end
`else
    checks++;
    if (is_crit !== 1'b1) begin errors++; $display("FAIL lh_still_held: got %b want 1", is_crit); end
`endif
    step();
  endtask

  task automatic test_random();
    do_clear();
    for (int c = 0; c < 400; c++) begin
      int sel;
      int idx;
      sel = $urandom_range(0, 7);
      case (sel)
        0: idx = 0;
        1, 2: idx = 1;
        3: idx = 8;
        4: idx = 9;
        5: idx = 2;
        default: idx = $urandom_range(0, 31);
      endcase
      clear = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 4) != 0, 1'($urandom), idx, $urandom_range(0, 3),
            3 + $urandom_range(0, 2), $urandom, $urandom_range(0, 3) == 0);
      checks++;
      if (dut_obs() !== model_exp()) begin
        errors++; $display("FAIL random cycle %0d: got %h want %h", c, dut_obs(), model_exp());
      end
      step();
      clear = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_contention();
    test_full_queue();
    test_simultaneous();
    test_softclear();
    test_reset_mid_job();
    test_lock_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hwpe_ctrl_job_dispatcher.md
# hwpe_ctrl_job_dispatcher

Upstream front-end of the HWPE control register file. It accepts peripheral-bus requests from cores, decodes each into a register-file access plus per-access flags (mandatory, contexted, read, testset, trigger), and owns the offload lock and the multi-context job queue. It also sequences jobs into the engine and reports completion. Its outputs drive the register file's input bundle and flags directly; the register file's read data returns through this block.

## Interface
- N_CONTEXT, 2: job contexts, power of two, 1..4.
- N_GENERIC_REGS, 0: non-contexted generic registers.
- N_IO_REGS, 2: contexted registers per context.
- ID_WIDTH, 16: bus transaction ID width.
- LOCK_TIMEOUT, 1024: lock auto-release cycles (see Configuration).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- clear_i  in  1  synchronous soft clear
- req_i / gnt_o  in/out  1  bus request / grant
- add_i  in  32  byte address; word index add_i[6:2], context select add_i[8:7]
- wen_i  in  1  1 = read, 0 = write
- be_i  in  4  byte enables
- data_i  in  32  write data
- id_i  in  ID_WIDTH  requester ID
- r_valid_o  out  1  response valid
- r_data_o  out  32  response data
- r_id_o  out  ID_WIDTH  response ID
- rf_addr_o  out  7  {context, word index} to register file
- rf_wren_o / rf_wdata_o / rf_be_o  out  1/32/4  register-file write
- rf_rdata_i  in  32  register-file read data, valid the cycle after the access
- is_mandatory_o, is_contexted_o, is_read_o, is_testset_o, is_trigger_o, is_critical_o, full_context_o, true_done_o  out  1 each  access flags
- pointer_context_o, running_context_o  out  max(1,log2 N_CONTEXT)  context pointers
- start_o  out  1  one-cycle engine start
- done_i  in  1  engine job done, one-cycle pulse
- evt_o  out  1  completion event
- busy_o  out  1  at least one job queued or running

## Operation
- Register map (word index): 0 TRIGGER (W), 1 ACQUIRE (R), 2 FINISHED, 3 STATUS, 4 RUNNING_JOB, 5 SOFTCLEAR, 6 SWEVT, 7 EXT. Indices 0–7 are mandatory. Indices 8 to 8+N_GENERIC_REGS-1 are generic. Higher indices are contexted.
- is_read_o = req_i & wen_i. is_testset_o = read of index 1. is_trigger_o = write of index 0 by the lock owner while the lock is held.
- Lock state machine: FREE -> LOCKED(owner = id_i) on an ACQUIRE while FREE and not full. LOCKED -> FREE on a trigger by the owner, or on clear_i.
  - ACQUIRE while LOCKED: is_critical_o = 1, no state change.
  - ACQUIRE while FREE and all N_CONTEXT contexts occupied: full_context_o = 1, no state change.
- Contexted write while LOCKED by the owner: rf_addr_o context field = pointer_context_o.
- Contexted write by a non-owner, or with no lock held: rf_wren_o = 0 (dropped); the response still returns.
- Contexted read: context field = add_i[8:7].
- Trigger: marks pointer context occupied; pointer advances mod N_CONTEXT; occupied count +1.
- Engine state machine:
  - IDLE -> START when the occupied count > 0.
  - START: start_o = 1 for one cycle -> RUN.
  - RUN, done_i: true_done_o pulses; running context advances mod N_CONTEXT; count -1 -> IDLE.
- evt_o pulses one cycle after true_done_o.
- Trigger and done_i in the same cycle: count unchanged (+1 -1), both pointers advance.
- clear_i, or a write to SOFTCLEAR: lock freed, count and both pointers 0, engine to IDLE. A SOFTCLEAR write applies on the next edge.

## Timing
- gnt_o = req_i (combinational, always grant).
- All rf_* and flag outputs are combinational from the current request and state. State updates on the edge ending the request.
- r_valid_o, r_id_o: registered, 1 cycle after grant. r_data_o = rf_rdata_i.
- Back-to-back requests are supported every cycle.
- Reset values: all outputs 0; lock FREE; count, pointers 0; engine IDLE.
- Trigger to start_o latency: 2 cycles when the engine is IDLE and the queue is empty (count update, then START).
- Reset asserted mid-job: immediate return to reset state. A done_i arriving after reset is ignored while IDLE.

## Configuration
- HWPE_CTRL_LOCK_TIMEOUT_EN defined: a counter runs while LOCKED and restarts on each owner access. After LOCK_TIMEOUT cycles with no owner access, the lock returns to FREE and nothing is enqueued.
- Undefined: the lock is held indefinitely; no counter is instantiated.

## Test plan
- Single job: ACQUIRE by ID 3 -> r_data_o = job id 0, lock owner 3; write index 8+N_GENERIC_REGS = 0x1234 -> rf_addr_o context 0; trigger -> start_o 2 cycles later; done_i -> true_done_o, evt_o next cycle, busy_o = 0.
- Contention: ID 3 holds lock; ACQUIRE by ID 5 -> is_critical_o = 1, owner unchanged; ID 5 contexted write -> rf_wren_o = 0.
- Full queue, N_CONTEXT = 2, engine stalled: two acquire+trigger cycles, then a third ACQUIRE -> full_context_o = 1; one done_i -> next ACQUIRE succeeds with pointer_context_o = 0 (wrapped).
- Simultaneous trigger and done_i in the same cycle -> count unchanged; pointer_context_o and running_context_o each +1.
- SOFTCLEAR write while RUN with lock held -> next cycle: busy_o = 0, lock FREE, pointers 0; a late done_i produces no true_done_o.
- With HWPE_CTRL_LOCK_TIMEOUT_EN, LOCK_TIMEOUT = 16: acquire, then idle 16 cycles -> lock FREE; an ACQUIRE by another ID succeeds.
